bram_wr: RTL and testbench

//   PL-side BRAM writer; the write-direction counterpart of the bram_rd block.

---
 rtl/bram_wr_pkg.sv | 27 ++
 rtl/bram_wr.sv | 124 ++++++++++++
 tb/tb_bram_wr.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_wr_pkg.sv
// Shared definitions for the PL-side BRAM writer.
// Holds the BRAM port geometry, the status-word magic value, the writer FSM
// state encoding and a helper that turns a word index into a byte address.
package bram_wr_pkg;

  localparam int          BRAM_ADDR_W = 32;
  localparam int          BRAM_DATA_W = 32;
  localparam logic [3:0]  BRAM_WE_ALL = 4'hF;
  localparam int          BRAM_BYTES  = 8192;
  localparam logic [15:0] FLAG_MAGIC  = 16'hA5A5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FLAG = 2'd2,
    ST_DONE = 2'd3
  } wr_state_t;

  // Byte address of a 32-bit word; plain 32-bit arithmetic, no wrap handling.
  function automatic logic [BRAM_ADDR_W-1:0] word_addr(
    input logic [BRAM_ADDR_W-1:0] base,
    input logic [BRAM_ADDR_W-1:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/bram_wr.sv
// bram_wr: packs a stream of 16-bit samples two per 32-bit word, writes one
// frame of NUM_WORDS words into the PS-shared BRAM starting at BASE_ADDR,
// then writes a status word {A5A5, frame_cnt} at FLAG_ADDR so software can
// see that the frame is complete.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start_wr            level input; a low->high edge arms one frame capture
//   data_in, data_valid 16-bit sample and its one-cycle qualifier
//   busy                high from arming until the done pulse
//   done                one-cycle pulse after the status word is written
//   ram_clk, ram_rst    BRAM port clock and active-low reset (pass-through)
//   ram_en, ram_we      registered BRAM enable and byte write enables
//   ram_addr            registered byte address
//   ram_wr_data         registered write data
module bram_wr
  import bram_wr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024,
  parameter logic [31:0] FLAG_ADDR = 32'h0000_1FFC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_wr,
  input  logic [15:0]            data_in,
  input  logic                   data_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_clk,
  output logic                   ram_rst,
  output logic                   ram_en,
  output logic [3:0]             ram_we,
  output logic [BRAM_ADDR_W-1:0] ram_addr,
  output logic [BRAM_DATA_W-1:0] ram_wr_data
);

  // One extra bit so the index can represent NUM_WORDS itself after the last
  // increment without aliasing to zero.
  localparam int               IDX_W    = $clog2(NUM_WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  wr_state_t        state;
  logic [IDX_W-1:0] word_idx;
  logic             half;
  logic [15:0]      lo_reg;
  logic [15:0]      frame_cnt;
  logic             start_d;
  logic             start_edge;

  assign ram_clk    = clk;
  assign ram_rst    = rst_n;
  assign start_edge = start_wr & ~start_d;

  // Writer FSM. ram_en/ram_we/done default low every cycle so they only
  // pulse on a write (or the completion cycle); address and data hold their
  // last value between writes. start_d is sampled every cycle so an edge that
  // happens while busy is consumed and never acted on later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      word_idx    <= '0;
      half        <= 1'b0;
      lo_reg      <= '0;
      frame_cnt   <= '0;
      start_d     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      start_d <= start_wr;
      ram_en  <= 1'b0;
      ram_we  <= '0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state    <= ST_FILL;
            busy     <= 1'b1;
            word_idx <= '0;
            half     <= 1'b0;
          end
        end
        ST_FILL: begin
          if (data_valid) begin
            if (!half) begin
              lo_reg <= data_in;
              half   <= 1'b1;
            end else begin
              // Second sample of the pair goes straight into the high half.
              ram_en      <= 1'b1;
              ram_we      <= BRAM_WE_ALL;
              ram_addr    <= word_addr(BASE_ADDR, 32'(word_idx));
              ram_wr_data <= {data_in, lo_reg};
              half        <= 1'b0;
              word_idx    <= word_idx + IDX_W'(1);
              if (word_idx == LAST_IDX) begin
                state <= ST_FLAG;
              end
            end
          end
        end
        ST_FLAG: begin
          ram_en      <= 1'b1;
          ram_we      <= BRAM_WE_ALL;
          ram_addr    <= FLAG_ADDR;
          ram_wr_data <= {FLAG_MAGIC, frame_cnt};
          frame_cnt   <= frame_cnt + 16'd1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_wr.sv
// Testbench for bram_wr with NUM_WORDS=4. Stimulus tasks push the expected
// BRAM writes (address, data, observation cycle) and done pulses into queues;
// a monitor on the falling edge pops and compares whenever the DUT strobes.
module tb_bram_wr;

  localparam int          NW     = 4;
  localparam logic [31:0] FLAG_A = 32'h0000_1FFC;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stamp;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_wr = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        busy, done, ram_clk, ram_rst, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wr_data;

  int      vectors = 0;
  int      miscompares = 0;
  int      cyc = 0;
  wr_exp_t wr_q[$];
  int      done_q[$];

  bram_wr #(
    .BASE_ADDR(32'h0000_0000),
    .NUM_WORDS(NW),
    .FLAG_ADDR(FLAG_A)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_wr(start_wr),
    .data_in(data_in),
    .data_valid(data_valid),
    .busy(busy),
    .done(done),
    .ram_clk(ram_clk),
    .ram_rst(ram_rst),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp expected strobes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue,
  // including the cycle it appears in; every done pulse likewise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en || ram_we != 4'h0) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write_addr", ram_addr, 32'hFFFF_FFFF);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          checkOutput("wr_addr", ram_addr, e.addr);
          checkOutput("wr_data", ram_wr_data, e.data);
          checkOutput("wr_en", 32'(ram_en), 32'd1);
          checkOutput("wr_we", 32'(ram_we), 32'hF);
          checkOutput("wr_cycle", 32'(cyc), 32'(e.stamp));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          int s;
          s = done_q.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(s));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // One frame of samples 0x0001..0x0008. gap = idle cycles between samples;
  // junk = drive 0xDEAD with valid in IDLE/FLAG/DONE; hold = keep start_wr
  // high through the frame with an extra low->high edge while busy.
  task automatic applyStimulus(input int gap, input bit junk, input bit hold, input logic [15:0] exp_cnt);
    logic [15:0] s [2*NW];
    int n;
    for (int i = 0; i < 2*NW; i++) s[i] = 16'(i + 1);
    if (junk) begin
      data_valid = 1'b1;
      data_in    = 16'hDEAD;
      repeat (2) @(negedge clk);
    end
    start_wr = 1'b1;
    @(negedge clk);
    checkOutput("busy_armed", 32'(busy), 32'd1);
    if (!hold) start_wr = 1'b0;
    for (int i = 0; i < 2*NW; i++) begin
      if (hold && i == 2) start_wr = 1'b0;
      if (hold && i == 3) start_wr = 1'b1;
      data_valid = 1'b1;
      data_in    = s[i];
      if (i % 2 == 1) begin
        wr_q.push_back('{addr: 32'(4 * (i / 2)), data: {s[i], s[i-1]}, stamp: cyc + 1});
        if (i / 2 == NW - 1) begin
          wr_q.push_back('{addr: FLAG_A, data: {16'hA5A5, exp_cnt}, stamp: cyc + 2});
          done_q.push_back(cyc + 3);
        end
      end
      @(negedge clk);
      if (i != 2*NW - 1) begin
        data_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    if (junk) data_in = 16'hDEAD;
    else data_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_falls", 32'(busy), 32'd0);
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        checkOutput("busy_no_retrigger", 32'(busy), 32'd0);
      end
      start_wr = 1'b0;
    end
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_en", 32'(ram_en), 32'd0);
    checkOutput("reset_data", ram_wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of FILL after three samples.
    $display("[TB] reset mid-frame");
    start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data_in    = 16'(i + 1);
      if (i == 1) wr_q.push_back('{addr: 32'h0, data: 32'h0002_0001, stamp: cyc + 1});
      @(negedge clk);
    end
    data_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_en", 32'(ram_en), 32'd0);
    checkOutput("abort_we", 32'(ram_we), 32'd0);
    checkOutput("abort_addr", ram_addr, 32'd0);
    checkOutput("abort_data", ram_wr_data, 32'd0);
    checkOutput("abort_ram_rst", 32'(ram_rst), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] back-to-back frame");
    applyStimulus(0, 1'b0, 1'b0, 16'h0000);
    $display("[TB] gapped frame");
    applyStimulus(2, 1'b0, 1'b0, 16'h0001);
    $display("[TB] junk outside FILL");
    applyStimulus(0, 1'b1, 1'b0, 16'h0002);
    $display("[TB] start held high");
    applyStimulus(0, 1'b0, 1'b1, 16'h0003);

    $display("[TB] frame counter wrap");
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    applyStimulus(1, 1'b0, 1'b0, 16'hFFFF);
    applyStimulus(0, 1'b0, 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    checkOutput("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
